// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes, functs, ALU codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_RTEX   = 4'd7,
        ST_RTWB   = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_BEQ    = 4'd11,
        ST_JMP    = 4'd12,
        ST_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOP_NONE parks alu_ctrl at 000 in states that do not use the ALU.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_t;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: ALUOp + funct -> alu_ctrl, plus funct legality for DECODE.
// Latency: combinational.
// Backpressure: none.
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_ctrl,
    output logic        funct_legal
);

    logic [2:0] funct_code;

    always_comb begin
        funct_code  = ALU_AND;
        funct_legal = 1'b0;
        case (funct)
            FN_ADD: begin funct_code = ALU_ADD; funct_legal = 1'b1; end
            FN_SUB: begin funct_code = ALU_SUB; funct_legal = 1'b1; end
            FN_AND: begin funct_code = ALU_AND; funct_legal = 1'b1; end
            FN_OR:  begin funct_code = ALU_OR;  funct_legal = 1'b1; end
            FN_SLT: begin funct_code = ALU_SLT; funct_legal = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_AND;
        case (alu_op)
            ALUOP_ADD:   alu_ctrl = ALU_ADD;
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: alu_ctrl = funct_code;
            default:     alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS main controller: Moore FSM driving datapath selects and write strobes.
// Latency: outputs combinational from state; lw 5, sw/R/addi 4, beq/j 3 enabled cycles.
// Backpressure: en low freezes state and gates all write strobes; selects hold.
module mc_ctrl_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        halted
);

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;
    logic   funct_legal;

    // Ungated strobes; en is applied once at the output.
    logic   pc_write_s;
    logic   branch_s;
    logic   mem_write_s;
    logic   ir_write_s;
    logic   reg_write_s;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_ctrl    (alu_ctrl),
        .funct_legal (funct_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_op      = ALUOP_NONE;
        iord        = 1'b0;
        pc_src      = PCSRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        halted      = 1'b0;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alu_src_b = SRCB_BOFF;
                alu_op    = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = funct_legal ? ST_RTEX : ST_HALT;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JMP;
                    default:      state_d = ST_HALT;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                iord    = 1'b1;
                state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = ST_RTWB;
            end
            ST_RTWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                reg_write_s = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_BEQ: begin
                alu_src_a = 1'b1;
                branch_s  = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                alu_op    = ALUOP_SUB;
                state_d   = ST_FETCH;
            end
            ST_JMP: begin
                pc_write_s = 1'b1;
                pc_src     = PCSRC_JUMP;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign mem_write = mem_write_s & en;
    assign ir_write  = ir_write_s  & en;
    assign reg_write = reg_write_s & en;
    assign pc_en     = (pc_write_s | (branch_s & zero)) & en;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: random instruction mix against a per-instruction
// phase table model, plus directed stall, halt and reset-abort checks.
module tb_mc_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       start;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, mem_write, ir_write, pc_en, alu_src_a, reg_write, mem_to_reg, reg_dst, halted;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctrl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .halted(halted)
    );

    // Observed bundle: iord,mem_write,ir_write,pc_en,pc_src[2],src_a,src_b[2],alu[3],rw,m2r,rdst,halted
    wire [15:0] obs = {iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                       alu_ctrl, reg_write, mem_to_reg, reg_dst, halted};

    // Phase meaning of one clock within an instruction.
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_ADDR = 3, P_RD = 4, P_LWB = 5,
                   P_WR = 6, P_REX = 7, P_RWB = 8, P_IEX = 9, P_IWB = 10, P_BEQ = 11,
                   P_JMP = 12, P_HALT = 13;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5;

    int seq [6][5] = '{
        '{P_FETCH, P_DECODE, P_ADDR, P_RD,  P_LWB},
        '{P_FETCH, P_DECODE, P_ADDR, P_WR,  0},
        '{P_FETCH, P_DECODE, P_REX,  P_RWB, 0},
        '{P_FETCH, P_DECODE, P_IEX,  P_IWB, 0},
        '{P_FETCH, P_DECODE, P_BEQ,  0,     0},
        '{P_FETCH, P_DECODE, P_JMP,  0,     0}
    };
    int seq_len [6] = '{5, 4, 4, 4, 3, 3};
    logic [5:0] kind_op [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    function automatic logic [2:0] fn_code(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] expect_out(input int ph, input logic [5:0] f,
                                               input logic z, input logic e);
        logic i_ = 0, mw = 0, irw = 0, pce = 0, sa = 0, rw = 0, m2r = 0, rd = 0, h = 0;
        logic [1:0] ps = 0, sb = 0;
        logic [2:0] ac = 0;
        case (ph)
            P_FETCH:  begin irw = e; pce = e; sb = 2'b01; ac = 3'b010; end
            P_DECODE: begin sb = 2'b11; ac = 3'b010; end
            P_ADDR,
            P_IEX:    begin sa = 1; sb = 2'b10; ac = 3'b010; end
            P_RD:     i_ = 1;
            P_LWB:    begin rw = e; m2r = 1; end
            P_WR:     begin i_ = 1; mw = e; end
            P_REX:    begin sa = 1; ac = fn_code(f); end
            P_RWB:    begin rw = e; rd = 1; end
            P_IWB:    rw = e;
            P_BEQ:    begin sa = 1; pce = z & e; ps = 2'b01; ac = 3'b110; end
            P_JMP:    begin pce = e; ps = 2'b10; end
            P_HALT:   h = 1;
            default:  ;
        endcase
        return {i_, mw, irw, pce, ps, sa, sb, ac, rw, m2r, rd, h};
    endfunction

    // Drive one cycle's inputs at negedge, compare mid-low-phase, leave the posedge to the caller.
    task automatic cyc(input int ph, input logic e, input logic z, input logic s,
                       input logic [5:0] o, input logic [5:0] f, input string tag);
        logic [15:0] exp_v;
        @(negedge clk);
        en = e; zero = z; start = s; op = o; funct = f;
        #1;
        exp_v = expect_out(ph, f, z, e);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s phase=%0d en=%0b obs=%h exp=%h", tag, ph, e, obs, exp_v);
        end
    endtask

    task automatic run_instr(input int k, input logic [5:0] f, input int stall_pct, input string tag);
        for (int i = 0; i < seq_len[k]; i++) begin
            while ($urandom_range(99) < stall_pct)
                cyc(seq[k][i], 1'b0, 1'($urandom), 1'($urandom), kind_op[k], f, {tag, "_stall"});
            cyc(seq[k][i], 1'b1, 1'($urandom), 1'($urandom), kind_op[k], f, tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; start = 1'b0; op = '0; funct = '0; zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; start = 1'b0; op = '0; funct = '0; zero = 1'b0;
        #1;
        tests++;
        assert (obs === 16'h0) else begin fails++; $error("FAIL reset_outs obs=%h exp=0000", obs); end
        do_reset();

        // IDLE ignores start while en is low, and stays put without start.
        cyc(P_IDLE, 1'b0, 1'b0, 1'b1, 6'b100011, 6'd0, "idle_start_en0");
        cyc(P_IDLE, 1'b1, 1'b0, 1'b0, 6'b100011, 6'd0, "idle_nostart");
        cyc(P_IDLE, 1'b1, 1'b0, 1'b1, 6'b100011, 6'd0, "idle_start");

        // Directed lw: F, D, MEMADR, MEMRD, MEMWB, then FETCH.
        run_instr(K_LW, 6'd0, 0, "lw_dir");
        // Directed R-type sub, then beq taken and not taken.
        run_instr(K_R, 6'b100010, 0, "rsub_dir");
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0, 6'b000100, 6'd0, "beq1_f");
        cyc(P_DECODE, 1'b1, 1'b0, 1'b0, 6'b000100, 6'd0, "beq1_d");
        cyc(P_BEQ, 1'b1, 1'b1, 1'b0, 6'b000100, 6'd0, "beq_taken");
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0, 6'b000100, 6'd0, "beq0_f");
        cyc(P_DECODE, 1'b1, 1'b0, 1'b0, 6'b000100, 6'd0, "beq0_d");
        cyc(P_BEQ, 1'b1, 1'b0, 1'b0, 6'b000100, 6'd0, "beq_not_taken");

        // sw with a 3-cycle stall inside MEMWR.
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0, 6'b101011, 6'd0, "sw_f");
        cyc(P_DECODE, 1'b1, 1'b0, 1'b0, 6'b101011, 6'd0, "sw_d");
        cyc(P_ADDR, 1'b1, 1'b0, 1'b0, 6'b101011, 6'd0, "sw_addr");
        for (int i = 0; i < 3; i++)
            cyc(P_WR, 1'b0, 1'b0, 1'b0, 6'b101011, 6'd0, "sw_stall");
        cyc(P_WR, 1'b1, 1'b0, 1'b0, 6'b101011, 6'd0, "sw_write");
        cyc(P_FETCH, 1'b0, 1'b0, 1'b0, 6'b101011, 6'd0, "sw_after_fetch");

        // Random instruction mix with random stalls and don't-care start/zero noise.
        for (int n = 0; n < 80; n++) begin
            int k;
            logic [5:0] f;
            k = $urandom_range(5);
            f = (k == K_R) ? legal_fn[$urandom_range(4)] : 6'($urandom);
            run_instr(k, f, 20, "rand");
        end

        // Illegal opcode halts; en, start and zero have no effect afterwards.
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0, 6'b111111, 6'd0, "ill_op_f");
        cyc(P_DECODE, 1'b1, 1'b0, 1'b0, 6'b111111, 6'd0, "ill_op_d");
        for (int i = 0; i < 12; i++)
            cyc(P_HALT, 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), "halt_op");

        // Asynchronous reset from HALT, then back in IDLE.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        assert (obs === 16'h0) else begin fails++; $error("FAIL halt_reset obs=%h exp=0000", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(P_IDLE, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000001, "idle_after_halt");
        cyc(P_IDLE, 1'b1, 1'b0, 1'b1, 6'b000000, 6'b000001, "idle_start2");

        // R-type with illegal funct halts.
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000001, "ill_fn_f");
        cyc(P_DECODE, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000001, "ill_fn_d");
        for (int i = 0; i < 12; i++)
            cyc(P_HALT, 1'($urandom), 1'($urandom), 1'($urandom), 6'b000000, 6'b000001, "halt_fn");
        do_reset();

        // Reset asserted in the middle of MEMWB aborts the write-back in the same cycle.
        cyc(P_IDLE, 1'b1, 1'b0, 1'b1, 6'b100011, 6'd0, "lw2_idle");
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0, 6'b100011, 6'd0, "lw2_f");
        cyc(P_DECODE, 1'b1, 1'b0, 1'b0, 6'b100011, 6'd0, "lw2_d");
        cyc(P_ADDR, 1'b1, 1'b0, 1'b0, 6'b100011, 6'd0, "lw2_addr");
        cyc(P_RD, 1'b1, 1'b0, 1'b0, 6'b100011, 6'd0, "lw2_rd");
        cyc(P_LWB, 1'b1, 1'b0, 1'b0, 6'b100011, 6'd0, "lw2_wb");
        rst_n = 1'b0;
        #1;
        tests++;
        assert (obs === 16'h0) else begin fails++; $error("FAIL memwb_abort obs=%h exp=0000", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(P_IDLE, 1'b1, 1'b0, 1'b0, 6'b100011, 6'd0, "idle_after_abort");
        cyc(P_IDLE, 1'b1, 1'b0, 1'b1, 6'b001000, 6'd0, "addi_idle");
        run_instr(K_ADDI, 6'd0, 0, "addi_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
